// File: rtl/ram_mmio_if.sv
// Request/completion bus for ram_mmio.
// The requester drives the master side and the memory drives the slave side.
interface ram_mmio_if;
  logic        enable;
  logic        ready;
  logic        valid;
  logic        err;
  logic [31:0] addr;
  logic [1:0]  oplen;
  logic        we;
  logic [31:0] data;
  logic [31:0] result;

  modport master (
    output enable, addr, oplen, we, data,
    input  ready, valid, err, result
  );

  modport slave (
    input  enable, addr, oplen, we, data,
    output ready, valid, err, result
  );
endinterface

// File: rtl/ram_mmio.sv
// Byte-addressed little-endian RAM with a configurable access latency and two
// MMIO registers: a GPIO output register and a synchronised GPIO input.
// Accesses that straddle a word boundary take one extra cycle, because the
// second word is handled in the SPLIT state.
module ram_mmio #(
  parameter int          DEPTH_WORDS   = 256,
  parameter int          READ_LATENCY  = 1,
  parameter int          GPIO_WIDTH    = 16,
  parameter logic [31:0] GPIO_OUT_ADDR = 32'hFFFFFFFF,
  parameter logic [31:0] GPIO_IN_ADDR  = 32'hFFFFFFFE,
  parameter              INIT_FILE     = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_mmio_if.slave             bus,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  input  logic [GPIO_WIDTH-1:0] gpio_in
);

  localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] CAPACITY   = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [1:0]  COUNT_LOAD = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, SPLIT} state_t;

  state_t                state_reg, state_next;
  logic [1:0]            count_reg, count_next;
  logic                  valid_reg, valid_next;
  logic                  err_reg, err_next;
  logic [31:0]           result_reg, result_next;
  logic [31:0]           partial_reg, partial_next;
  logic [GPIO_WIDTH-1:0] gpio_out_reg, gpio_out_next;
  logic [GPIO_WIDTH-1:0] sync1_reg, sync2_reg;

  // Captured request; the class bits are decided once, at acceptance.
  logic [AW-1:0] word_reg;
  logic [1:0]    off_reg;
  logic [1:0]    oplen_reg;
  logic          we_reg;
  logic [31:0]   data_reg;
  logic          gout_reg, gin_reg, oor_reg, split_reg;

  logic [31:0] ram [DEPTH_WORDS];

  logic          accept;
  logic          in_gout, in_gin, in_mmio, in_oor, in_split;
  logic [32:0]   in_end;
  logic          phase;
  logic [AW-1:0] access_idx;
  logic [31:0]   rd_word;
  logic [31:0]   wr_word;
  logic [31:0]   rd_merged;
  logic [3:0]    lane_en;
  logic [3:0]    ram_wen;
  logic [1:0]    lane_pos [4];

  // Classify the incoming request. An MMIO address match wins over the range
  // check, so the top of the address space never reports out-of-range.
  always_comb begin
    in_gout  = (bus.addr == GPIO_OUT_ADDR);
    in_gin   = (bus.addr == GPIO_IN_ADDR) && !in_gout;
    in_mmio  = in_gout || in_gin;
    in_end   = {1'b0, bus.addr} + 33'(bus.oplen) + 33'd1;
    in_oor   = !in_mmio && (in_end > CAPACITY);
    in_split = !in_mmio && !in_oor &&
               (({1'b0, bus.addr[1:0]} + {1'b0, bus.oplen}) >= 3'd4);
  end

  assign accept = bus.enable && (state_reg == IDLE) && !rst;

  // Second pass of a split access works on the following word.
  assign phase      = (state_reg == SPLIT);
  assign access_idx = word_reg + AW'(phase);
  assign rd_word    = ram[access_idx];

  // Per byte lane: its position within the access (wrapping negative offsets
  // out of range), whether it takes part, and which data byte it carries.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [3:0] pos;
    assign pos          = 4'(gi) + (phase ? 4'd4 : 4'd0) - {2'b00, off_reg};
    assign lane_en[gi]  = pos < ({2'b00, oplen_reg} + 4'd1);
    assign lane_pos[gi] = pos[1:0];
    assign wr_word[8*gi +: 8] = data_reg[8*pos[1:0] +: 8];
  end

  // Place the lanes that were read at their position in the result; the
  // second word of a split read is merged onto the first word's bytes.
  always_comb begin
    rd_merged = phase ? partial_reg : 32'd0;
    for (int l = 0; l < 4; l++) begin
      if (lane_en[l]) rd_merged[8*lane_pos[l] +: 8] = rd_word[8*l +: 8];
    end
  end

  // Next-state and completion logic for the IDLE/WAIT/SPLIT sequencer.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    valid_next    = 1'b0;
    err_next      = 1'b0;
    result_next   = result_reg;
    partial_next  = partial_reg;
    gpio_out_next = gpio_out_reg;
    ram_wen       = 4'b0000;
    unique case (state_reg)
      IDLE: begin
        if (bus.enable) begin
          state_next = WAIT;
          count_next = in_mmio ? 2'd0 : COUNT_LOAD;
        end
      end
      WAIT: begin
        if (count_reg != 2'd0) begin
          count_next = count_reg - 2'd1;
        end else if (gout_reg) begin
          if (we_reg) gpio_out_next = data_reg[GPIO_WIDTH-1:0];
          else        result_next   = 32'(gpio_out_reg);
          valid_next = 1'b1;
          state_next = IDLE;
        end else if (gin_reg) begin
          if (we_reg) err_next    = 1'b1;
          else        result_next = 32'(sync2_reg);
          valid_next = 1'b1;
          state_next = IDLE;
        end else if (oor_reg) begin
          result_next = 32'd0;
          err_next    = 1'b1;
          valid_next  = 1'b1;
          state_next  = IDLE;
        end else begin
          if (we_reg)         ram_wen      = lane_en & {4{!rst}};
          else if (split_reg) partial_next = rd_merged;
          else                result_next  = rd_merged;
          if (split_reg) begin
            state_next = SPLIT;
          end else begin
            valid_next = 1'b1;
            state_next = IDLE;
          end
        end
      end
      SPLIT: begin
        if (we_reg) ram_wen     = lane_en & {4{!rst}};
        else        result_next = rd_merged;
        valid_next = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sequencer, completion and GPIO registers, plus the input synchroniser.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      count_reg    <= 2'd0;
      valid_reg    <= 1'b0;
      err_reg      <= 1'b0;
      result_reg   <= 32'd0;
      partial_reg  <= 32'd0;
      gpio_out_reg <= '0;
      sync1_reg    <= '0;
      sync2_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      valid_reg    <= valid_next;
      err_reg      <= err_next;
      result_reg   <= result_next;
      partial_reg  <= partial_next;
      gpio_out_reg <= gpio_out_next;
      sync1_reg    <= gpio_in;
      sync2_reg    <= sync1_reg;
    end
  end

  // Capture the request at acceptance so later bus changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      word_reg  <= bus.addr[AW+1:2];
      off_reg   <= bus.addr[1:0];
      oplen_reg <= bus.oplen;
      we_reg    <= bus.we;
      data_reg  <= bus.data;
      gout_reg  <= in_gout;
      gin_reg   <= in_gin;
      oor_reg   <= in_oor;
      split_reg <= in_split;
    end
  end

  // RAM byte-lane writes; contents are deliberately untouched by reset.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (ram_wen[l]) ram[access_idx][8*l +: 8] <= wr_word[8*l +: 8];
    end
  end

  assign bus.ready  = (state_reg == IDLE);
  assign bus.valid  = valid_reg;
  assign bus.err    = err_reg;
  assign bus.result = result_reg;
  assign gpio_out   = gpio_out_reg;

endmodule
